vx_fpu_csr_file: RTL and testbench

VX_FPU_CSR_FILE -- requirements
Module: VX_fpu_csr_file

---
 rtl/vx_fpu_csr_file.sv | 157 +++++++++++++++
 tb/tb_vx_fpu_csr_file.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fpu_csr_file.sv
// Per-warp FPU control/status: rounding mode, accrued exception flags and in-flight
// op counters, with a stalling CSR port that only touches a warp once its FPU ops drain.
module vx_fpu_csr_file #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_BLOCKS  = 1,
   parameter int MAX_PENDING = 15,
   localparam int NW   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int BW   = $clog2(NUM_BLOCKS),
   localparam int BNW  = ((NW - BW) > 1) ? (NW - BW) : 1,
   localparam int CNTW = $clog2(MAX_PENDING + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_BLOCKS-1:0][BNW-1:0]  read_wid,
   output logic [NUM_BLOCKS-1:0][2:0]      read_frm,
   input  logic [NUM_BLOCKS-1:0]           write_enable,
   input  logic [NUM_BLOCKS-1:0][BNW-1:0]  write_wid,
   input  logic [NUM_BLOCKS-1:0][4:0]      write_fflags,
   input  logic                            issue_valid,
   input  logic [NW-1:0]                   issue_wid,
   output logic                            issue_ready,
   input  logic                            commit_valid,
   input  logic [NW-1:0]                   commit_wid,
   input  logic                            csr_req_valid,
   output logic                            csr_req_ready,
   input  logic [NW-1:0]                   csr_req_wid,
   input  logic [11:0]                     csr_req_addr,
   input  logic [1:0]                      csr_req_op,
   input  logic [31:0]                     csr_req_data,
   output logic                            csr_rsp_valid,
   input  logic                            csr_rsp_ready,
   output logic [31:0]                     csr_rsp_data
);

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_SET   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   logic [2:0]      frm_q     [NUM_WARPS];
   logic [4:0]      fflags_q  [NUM_WARPS];
   logic [CNTW-1:0] pending_q [NUM_WARPS];
   logic [4:0]      blk_or    [NUM_WARPS];
   logic [NUM_WARPS-1:0] pend_inc, pend_dec;

   logic            commit_d1_valid;
   logic [NW-1:0]   commit_d1_wid;
   logic            rsp_valid_q;
   logic [7:0]      rsp_data_q;

   logic            issue_fire, csr_fire, csr_wr, wr_ff, wr_frm;
   logic [7:0]      csr_old, csr_new;
   logic [4:0]      new_ff;
   logic [2:0]      new_frm;
   logic            unused_csr_bits;

   // Block b serves the warps whose low BW bits equal b.
   function automatic logic [NW-1:0] full_wid(input logic [BNW-1:0] rwid, input int b);
      return NW'((32'(rwid) << BW) | 32'(b));
   endfunction

   always_comb begin
      read_frm = '0;
      for (int b = 0; b < NUM_BLOCKS; b++)
         read_frm[b] = frm_q[full_wid(read_wid[b], b)];
   end

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) blk_or[w] = '0;
      for (int w = 0; w < NUM_WARPS; w++)
         for (int b = 0; b < NUM_BLOCKS; b++)
            if (write_enable[b] && full_wid(write_wid[b], b) == NW'(w))
               blk_or[w] = blk_or[w] | write_fflags[b];
   end

   assign issue_ready = (pending_q[issue_wid] != CNTW'(MAX_PENDING));
   assign issue_fire  = issue_valid && issue_ready;

   always_comb begin
      pend_inc = '0;
      pend_dec = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         pend_inc[w] = issue_fire && (issue_wid == NW'(w));
         pend_dec[w] = commit_valid && (commit_wid == NW'(w)) && (pending_q[w] != '0);
      end
   end

   // commit_d1 covers the fflags write that trails the final commit by one cycle.
   assign csr_req_ready = (pending_q[csr_req_wid] == '0)
                        && !(commit_d1_valid && (commit_d1_wid == csr_req_wid))
                        && (!rsp_valid_q || csr_rsp_ready);
   assign csr_fire = csr_req_valid && csr_req_ready;

   always_comb begin
      csr_old = '0;
      case (csr_req_addr)
         12'h001: csr_old = {3'b000, fflags_q[csr_req_wid]};
         12'h002: csr_old = {5'b00000, frm_q[csr_req_wid]};
         12'h003: csr_old = {frm_q[csr_req_wid], fflags_q[csr_req_wid]};
         default: csr_old = '0;
      endcase
      case (csr_req_op)
         OP_WRITE: csr_new = csr_req_data[7:0];
         OP_SET:   csr_new = csr_old | csr_req_data[7:0];
         OP_CLEAR: csr_new = csr_old & ~csr_req_data[7:0];
         default:  csr_new = csr_old;
      endcase
      csr_wr  = csr_fire && (csr_req_op != OP_READ);
      wr_ff   = csr_wr && (csr_req_addr == 12'h001 || csr_req_addr == 12'h003);
      wr_frm  = csr_wr && (csr_req_addr == 12'h002 || csr_req_addr == 12'h003);
      new_ff  = csr_new[4:0];
      new_frm = (csr_req_addr == 12'h003) ? csr_new[7:5] : csr_new[2:0];
   end

   // No field is wider than 8 bits, so the operand's upper bits never matter.
   assign unused_csr_bits = ^csr_req_data[31:8];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            frm_q[w]     <= '0;
            fflags_q[w]  <= '0;
            pending_q[w] <= '0;
         end
         commit_d1_valid <= 1'b0;
         commit_d1_wid   <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_data_q      <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            // A CSR write overrides any same-cycle block accumulate.
            if (wr_ff && (csr_req_wid == NW'(w)))
               fflags_q[w] <= new_ff;
            else
               fflags_q[w] <= fflags_q[w] | blk_or[w];
            if (wr_frm && (csr_req_wid == NW'(w)))
               frm_q[w] <= new_frm;
            if (pend_inc[w] && !pend_dec[w])
               pending_q[w] <= pending_q[w] + CNTW'(1);
            else if (pend_dec[w] && !pend_inc[w])
               pending_q[w] <= pending_q[w] - CNTW'(1);
         end
         commit_d1_valid <= commit_valid;
         commit_d1_wid   <= commit_wid;
         if (csr_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= csr_old;
         end else if (csr_rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign csr_rsp_valid = rsp_valid_q;
   assign csr_rsp_data  = reset ? 32'd0 : {24'd0, rsp_data_q};

endmodule

// File: tb/tb_vx_fpu_csr_file.sv
// Bench for vx_fpu_csr_file (4 warps, 2 blocks): CSR vector table, directed
// corner sequences and a randomized run against a per-warp array model.
module tb_vx_fpu_csr_file;
   localparam int NWARP = 4;
   localparam int NB    = 2;
   localparam int MAXP  = 15;
   localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_SET = 2'd2, OP_CLR = 2'd3;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0][0:0]  read_wid;
   logic [1:0][2:0]  read_frm;
   logic [1:0]       write_enable;
   logic [1:0][0:0]  write_wid;
   logic [1:0][4:0]  write_fflags;
   logic             issue_valid, issue_ready, commit_valid;
   logic [1:0]       issue_wid, commit_wid;
   logic             csr_req_valid, csr_req_ready, csr_rsp_valid, csr_rsp_ready;
   logic [1:0]       csr_req_wid;
   logic [11:0]      csr_req_addr;
   logic [1:0]       csr_req_op;
   logic [31:0]      csr_req_data, csr_rsp_data;

   vx_fpu_csr_file #(.NUM_WARPS(NWARP), .NUM_BLOCKS(NB), .MAX_PENDING(MAXP)) dut (
      .clk(clk), .reset(reset),
      .read_wid(read_wid), .read_frm(read_frm),
      .write_enable(write_enable), .write_wid(write_wid), .write_fflags(write_fflags),
      .issue_valid(issue_valid), .issue_wid(issue_wid), .issue_ready(issue_ready),
      .commit_valid(commit_valid), .commit_wid(commit_wid),
      .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
      .csr_req_wid(csr_req_wid), .csr_req_addr(csr_req_addr),
      .csr_req_op(csr_req_op), .csr_req_data(csr_req_data),
      .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
      .csr_rsp_data(csr_rsp_data)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;
   int conflicts = 0;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } csr_vec_t;
   csr_vec_t vecs[17];

   // Model state for the randomized run.
   int m_frm[NWARP], m_ff[NWARP], m_pend[NWARP];
   bit m_cd1_v, m_rv;
   int m_cd1_w, m_rd;
   logic [31:0] r_old, r_new, rsp;
   bit e_ir, e_rr, r_fire;
   int r_full;

   function automatic int wmap(input int r, input int b);
      return r * NB + b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic idle();
      issue_valid = 0; issue_wid = 0; commit_valid = 0; commit_wid = 0;
      write_enable = '0; write_wid = '0; write_fflags = '0; read_wid = '0;
      csr_req_valid = 0; csr_req_wid = 0; csr_req_addr = 0; csr_req_op = 0;
      csr_req_data = 0; csr_rsp_ready = 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; idle();
      #1 chk("rst_rsp_data", csr_rsp_data, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      #1;
   endtask

   task automatic csr_xfer(input logic [1:0] op, input logic [11:0] addr, input logic [1:0] wid,
                           input logic [31:0] data, output logic [31:0] rdata);
      int n;
      @(negedge clk);
      csr_req_valid = 1; csr_req_op = op; csr_req_addr = addr;
      csr_req_wid = wid; csr_req_data = data; csr_rsp_ready = 1;
      #1;
      n = 0;
      while (!csr_req_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (!csr_req_ready) begin
         chk("csr_req_ready_timeout", {31'd0, csr_req_ready}, 1);
         csr_req_valid = 0;
         rdata = 32'hDEAD_BEEF;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      csr_req_valid = 0;
      #1;
      chk("csr_rsp_valid", {31'd0, csr_rsp_valid}, 1);
      rdata = csr_rsp_data;
   endtask

   // A CSR fflags write and a block write to the same warp must never coincide.
   always @(negedge clk) begin
      #2;
      if (!reset && csr_req_valid && csr_req_ready && csr_req_op != OP_RD &&
          (csr_req_addr == 12'h001 || csr_req_addr == 12'h003))
         for (int b = 0; b < NB; b++)
            if (write_enable[b] && wmap(int'(write_wid[b]), b) == int'(csr_req_wid))
               conflicts++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{OP_WR,  12'h003, 32'h0000_00FF, 32'h00};
      vecs[1]  = '{OP_CLR, 12'h003, 32'h0000_001F, 32'hFF};
      vecs[2]  = '{OP_RD,  12'h003, 32'h0000_0000, 32'hE0};
      vecs[3]  = '{OP_RD,  12'h002, 32'h0000_0000, 32'h07};
      vecs[4]  = '{OP_RD,  12'h001, 32'h0000_0000, 32'h00};
      vecs[5]  = '{OP_SET, 12'h001, 32'h0000_0013, 32'h00};
      vecs[6]  = '{OP_RD,  12'h003, 32'h0000_0000, 32'hF3};
      vecs[7]  = '{OP_WR,  12'h002, 32'hFFFF_FFFA, 32'h07};
      vecs[8]  = '{OP_RD,  12'h003, 32'h0000_0000, 32'h53};
      vecs[9]  = '{OP_WR,  12'h7FF, 32'h0000_0055, 32'h00};
      vecs[10] = '{OP_RD,  12'h7FF, 32'h0000_0000, 32'h00};
      vecs[11] = '{OP_CLR, 12'h002, 32'h0000_0002, 32'h02};
      vecs[12] = '{OP_RD,  12'h003, 32'h0000_0000, 32'h13};
      vecs[13] = '{OP_WR,  12'h001, 32'hFFFF_FFE4, 32'h13};
      vecs[14] = '{OP_RD,  12'h001, 32'h0000_0000, 32'h04};
      vecs[15] = '{OP_SET, 12'h000, 32'h0000_00FF, 32'h00};
      vecs[16] = '{OP_RD,  12'h003, 32'h0000_0000, 32'h04};

      reset = 1; idle();
      do_reset();

      // Reset state and frm write on warp 1.
      chk("rst_issue_ready", {31'd0, issue_ready}, 1);
      chk("rst_rsp_valid", {31'd0, csr_rsp_valid}, 0);
      chk("rst_req_ready", {31'd0, csr_req_ready}, 1);
      chk("rst_read_frm", {26'd0, read_frm}, 0);
      csr_xfer(OP_WR, 12'h002, 2'd1, 32'd3, rsp);
      chk("frm_w1_rsp", rsp, 0);
      read_wid[0] = 0; read_wid[1] = 0;
      #1 chk("frm_w1", {29'd0, read_frm[1]}, 3);
      chk("frm_w0", {29'd0, read_frm[0]}, 0);
      read_wid[0] = 1; read_wid[1] = 1;
      #1 chk("frm_w2_w3", {26'd0, read_frm}, 0);

      // CSR vector table on warp 3.
      do_reset();
      foreach (vecs[i]) begin
         csr_xfer(vecs[i].op, vecs[i].addr, 2'd3, vecs[i].data, rsp);
         chk($sformatf("vec%0d", i), rsp, vecs[i].exp);
      end

      // Read of fflags stalls behind two in-flight ops on warp 2.
      do_reset();
      @(negedge clk); issue_valid = 1; issue_wid = 2;
      #1 chk("w2_issue0", {31'd0, issue_ready}, 1);
      @(negedge clk);
      #1 chk("w2_issue1", {31'd0, issue_ready}, 1);
      @(negedge clk); issue_valid = 0;
      csr_req_valid = 1; csr_req_op = OP_RD; csr_req_addr = 12'h001; csr_req_wid = 2;
      #1 chk("w2_stall_pend2", {31'd0, csr_req_ready}, 0);
      @(negedge clk); write_enable = 2'b01; write_wid[0] = 1; write_fflags[0] = 5'h01;
      commit_valid = 1; commit_wid = 2;
      #1 chk("w2_stall_c1", {31'd0, csr_req_ready}, 0);
      @(negedge clk); write_fflags[0] = 5'h04;
      #1 chk("w2_stall_c2", {31'd0, csr_req_ready}, 0);
      @(negedge clk); write_enable = 0; commit_valid = 0;
      #1 chk("w2_stall_d1", {31'd0, csr_req_ready}, 0);
      @(negedge clk);
      #1 chk("w2_ready", {31'd0, csr_req_ready}, 1);
      @(posedge clk); @(negedge clk); csr_req_valid = 0;
      #1 chk("w2_rsp_valid", {31'd0, csr_rsp_valid}, 1);
      chk("w2_rsp_fflags", csr_rsp_data, 32'h05);

      // Two blocks, same reduced wid, land on different warps.
      do_reset();
      @(negedge clk); write_enable = 2'b11; write_wid[0] = 0; write_wid[1] = 0;
      write_fflags[0] = 5'h02; write_fflags[1] = 5'h08;
      @(negedge clk); idle();
      csr_xfer(OP_RD, 12'h001, 2'd0, 0, rsp); chk("blk_w0", rsp, 32'h02);
      csr_xfer(OP_RD, 12'h001, 2'd1, 0, rsp); chk("blk_w1", rsp, 32'h08);
      csr_xfer(OP_RD, 12'h003, 2'd2, 0, rsp); chk("blk_w2", rsp, 32'h00);

      // Pending counter saturation on warp 3.
      do_reset();
      for (int i = 0; i < MAXP; i++) begin
         @(negedge clk); issue_valid = 1; issue_wid = 3;
         #1 chk($sformatf("fill%0d", i), {31'd0, issue_ready}, 1);
      end
      @(negedge clk);
      #1 chk("full_ready", {31'd0, issue_ready}, 0);
      @(negedge clk); issue_valid = 0; commit_valid = 1; commit_wid = 3;
      #1 chk("full_commit_cyc", {31'd0, issue_ready}, 0);
      @(negedge clk); commit_valid = 0;
      #1 chk("after_commit", {31'd0, issue_ready}, 1);
      @(negedge clk); issue_valid = 1; commit_valid = 1;
      #1 chk("same_cyc", {31'd0, issue_ready}, 1);
      @(negedge clk); issue_valid = 0; commit_valid = 0;
      #1 chk("same_cyc_after", {31'd0, issue_ready}, 1);
      @(negedge clk); issue_valid = 1;
      @(negedge clk); issue_valid = 0;
      #1 chk("refull", {31'd0, issue_ready}, 0);
      @(negedge clk); commit_valid = 1;
      @(negedge clk); commit_valid = 0;
      #1 chk("reassert", {31'd0, issue_ready}, 1);
      @(negedge clk); commit_valid = 1; commit_wid = 0; issue_wid = 0;
      @(negedge clk); commit_valid = 0;
      @(negedge clk); csr_req_wid = 0;
      #1 chk("no_underflow_issue", {31'd0, issue_ready}, 1);
      chk("no_underflow_csr", {31'd0, csr_req_ready}, 1);

      // Response backpressure, then reset during the stall.
      do_reset();
      csr_xfer(OP_WR, 12'h003, 2'd1, 32'hAB, rsp);
      chk("bp_setup_rsp", rsp, 0);
      @(negedge clk); issue_valid = 1; issue_wid = 2;
      @(negedge clk); issue_valid = 0;
      @(negedge clk); csr_req_valid = 1; csr_req_op = OP_RD; csr_req_addr = 12'h003;
      csr_req_wid = 1; csr_rsp_ready = 0;
      #1 chk("bp_first_ready", {31'd0, csr_req_ready}, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); csr_req_wid = 0;
         #1 chk($sformatf("bp_valid%0d", i), {31'd0, csr_rsp_valid}, 1);
         chk($sformatf("bp_data%0d", i), csr_rsp_data, 32'hAB);
         chk($sformatf("bp_block%0d", i), {31'd0, csr_req_ready}, 0);
      end
      @(negedge clk); reset = 1; csr_req_valid = 0;
      #1 chk("bp_rst_data", csr_rsp_data, 0);
      @(negedge clk); reset = 0; csr_rsp_ready = 1; read_wid = '0;
      issue_wid = 2; csr_req_wid = 2;
      #1 chk("bp_rst_valid", {31'd0, csr_rsp_valid}, 0);
      chk("bp_rst_frm", {26'd0, read_frm}, 0);
      chk("bp_rst_pend_issue", {31'd0, issue_ready}, 1);
      chk("bp_rst_pend_csr", {31'd0, csr_req_ready}, 1);
      csr_xfer(OP_RD, 12'h003, 2'd1, 0, rsp);
      chk("bp_rst_fcsr", rsp, 0);

      // Randomized run against the array model.
      do_reset();
      for (int w = 0; w < NWARP; w++) begin m_frm[w] = 0; m_ff[w] = 0; m_pend[w] = 0; end
      m_cd1_v = 0; m_cd1_w = 0; m_rv = 0; m_rd = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         issue_valid  = ($urandom_range(0, 2) != 0);
         issue_wid    = 2'($urandom_range(0, 3));
         commit_valid = ($urandom_range(0, 2) == 0);
         commit_wid   = 2'($urandom_range(0, 3));
         for (int b = 0; b < NB; b++) begin
            read_wid[b]     = 1'($urandom_range(0, 1));
            write_wid[b]    = 1'($urandom_range(0, 1));
            write_fflags[b] = 5'($urandom);
            r_full = wmap(int'(write_wid[b]), b);
            write_enable[b] = ($urandom_range(0, 1) == 1) &&
                              (m_pend[r_full] > 0 || (m_cd1_v && m_cd1_w == r_full));
         end
         csr_req_valid = ($urandom_range(0, 1) == 1);
         csr_req_wid   = 2'($urandom_range(0, 3));
         csr_req_op    = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: csr_req_addr = 12'h001;
            1: csr_req_addr = 12'h002;
            2: csr_req_addr = 12'h003;
            3: csr_req_addr = 12'h000;
            default: csr_req_addr = 12'($urandom_range(4, 4095));
         endcase
         csr_req_data  = $urandom;
         csr_rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         e_ir = (m_pend[issue_wid] != MAXP);
         e_rr = (m_pend[csr_req_wid] == 0) && !(m_cd1_v && m_cd1_w == int'(csr_req_wid)) &&
                (!m_rv || csr_rsp_ready);
         chk("rnd_issue_ready", {31'd0, issue_ready}, {31'd0, e_ir});
         chk("rnd_req_ready", {31'd0, csr_req_ready}, {31'd0, e_rr});
         chk("rnd_frm0", {29'd0, read_frm[0]}, 32'(m_frm[wmap(int'(read_wid[0]), 0)]));
         chk("rnd_frm1", {29'd0, read_frm[1]}, 32'(m_frm[wmap(int'(read_wid[1]), 1)]));
         chk("rnd_rsp_valid", {31'd0, csr_rsp_valid}, {31'd0, m_rv});
         if (m_rv) chk("rnd_rsp_data", csr_rsp_data, 32'(m_rd));

         case (csr_req_addr)
            12'h001: r_old = 32'(m_ff[csr_req_wid]);
            12'h002: r_old = 32'(m_frm[csr_req_wid]);
            12'h003: r_old = 32'(m_frm[csr_req_wid] * 32 + m_ff[csr_req_wid]);
            default: r_old = 0;
         endcase
         case (csr_req_op)
            OP_WR:   r_new = csr_req_data;
            OP_SET:  r_new = r_old | csr_req_data;
            OP_CLR:  r_new = r_old & ~csr_req_data;
            default: r_new = r_old;
         endcase
         r_fire = csr_req_valid && e_rr;
         for (int b = 0; b < NB; b++)
            if (write_enable[b])
               m_ff[wmap(int'(write_wid[b]), b)] |= int'(write_fflags[b]);
         if (r_fire && csr_req_op != OP_RD) begin
            case (csr_req_addr)
               12'h001: m_ff[csr_req_wid] = int'(r_new % 32);
               12'h002: m_frm[csr_req_wid] = int'(r_new % 8);
               12'h003: begin
                  m_ff[csr_req_wid]  = int'(r_new % 32);
                  m_frm[csr_req_wid] = int'((r_new / 32) % 8);
               end
               default: ;
            endcase
         end
         if (r_fire) begin m_rv = 1; m_rd = int'(r_old); end
         else if (csr_rsp_ready) m_rv = 0;
         for (int w = 0; w < NWARP; w++) begin
            bit inc, dec;
            inc = issue_valid && e_ir && int'(issue_wid) == w;
            dec = commit_valid && int'(commit_wid) == w && m_pend[w] > 0;
            if (inc && !dec) m_pend[w]++;
            else if (dec && !inc) m_pend[w]--;
         end
         m_cd1_v = commit_valid;
         m_cd1_w = int'(commit_wid);
      end
      @(negedge clk); idle();

      chk("csr_block_conflicts", 32'(conflicts), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
